// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, default operand width and issuer FSM state type.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 13;
  localparam int unsigned OP_W           = 3;

  // ALU opcode encodings as seen on cmd_opcode / alu_opcode
  typedef enum logic [OP_W-1:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOD  = 3'b100,
    OP_GT   = 3'b101,
    OP_SHR  = 3'b110,
    OP_SHL  = 3'b111
  } alu_op_e;

  // Issuer sequencing: wait for work, launch it, wait for ALU, hold response
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } issuer_state_e;

  // True for opcodes that fault on a zero divisor
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command FIFO with registered full/empty flags; head is read combinationally.
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Next pointer/occupancy; a push while full or a pop while empty is ignored
  always_comb begin
    push_ok  = push_i && !full_q;
    pop_ok   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; contents need no reset since empty_q guards reads
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them one at a time to an external ALU and
// returns tagged responses in acceptance order.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_opcode,
  input  logic [DATA_W-1:0]       cmd_x,
  input  logic [DATA_W-1:0]       cmd_y,
  output logic [2:0]              alu_opcode,
  output logic [DATA_W-1:0]       alu_x,
  output logic [DATA_W-1:0]       alu_y,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  rsp_tag
);

  localparam int unsigned TAG_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = TAG_W + OP_W + 2 * DATA_W;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  issuer_state_e      state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   inflight_tag_q;
  logic [CNT_W-1:0]   lat_cnt_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [DATA_W-1:0]  alu_x_q, alu_y_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic               rsp_zero_q, rsp_err_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [ENT_W-1:0]   fifo_wdata, fifo_rdata;
  logic [DATA_W-1:0]  head_x, head_y;
  logic [OP_W-1:0]    head_op;
  logic [TAG_W-1:0]   head_tag;

  // Entry layout: {tag, opcode, x, y}
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == ST_ISSUE);
  assign fifo_wdata = {tag_q, cmd_opcode, cmd_x, cmd_y};
  assign head_y     = fifo_rdata[DATA_W-1:0];
  assign head_x     = fifo_rdata[2*DATA_W-1:DATA_W];
  assign head_op    = fifo_rdata[2*DATA_W +: OP_W];
  assign head_tag   = fifo_rdata[2*DATA_W+OP_W +: TAG_W];

  cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (aclk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequence number stamped on every accepted command; wraps naturally
  always_ff @(posedge aclk) begin
    if (reset) begin
      tag_q <= '0;
    end else if (push) begin
      tag_q <= tag_q + TAG_W'(1);
    end
  end

  // Issue FSM with registered ALU drive and response outputs
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      inflight_tag_q <= '0;
      lat_cnt_q      <= '0;
      alu_op_q       <= '0;
      alu_x_q        <= '0;
      alu_y_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_div_op(head_op) && (head_y == '0)) begin
            // Zero divisor: answer directly, leave the ALU drive untouched
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_tag_q    <= head_tag;
            state_q      <= ST_RESP;
          end else begin
            alu_op_q       <= head_op;
            alu_x_q        <= head_x;
            alu_y_q        <= head_y;
            inflight_tag_q <= head_tag;
            lat_cnt_q      <= '0;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == CNT_W'(ALU_LAT - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_status;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= inflight_tag_q;
            state_q      <= ST_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= fifo_empty ? ST_IDLE : ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign alu_opcode = alu_op_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a single-cycle ALU model.
module tb_alu_cmd_issuer;

  localparam int unsigned DW  = 13;
  localparam int LIMIT        = 200;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode = '0;
  logic [DW-1:0] cmd_x = '0, cmd_y = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_x, alu_y, alu_result;
  logic          alu_status;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero, rsp_err;
  logic [2:0]    rsp_tag;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
    logic [2:0]    tag;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_tag = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 aclk = ~aclk;

  alu_cmd_issuer #(.DATA_W(DW), .DEPTH(4), .ALU_LAT(1)) dut (
    .aclk       (aclk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .alu_opcode (alu_opcode),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag)
  );

  // ALU with ALU_LAT=1: result settles within the cycle after operands change
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_x;
      3'b001:  alu_result = alu_x + alu_y;
      3'b010:  alu_result = alu_x - alu_y;
      3'b011:  alu_result = (alu_y != '0) ? alu_x / alu_y : '0;
      3'b100:  alu_result = (alu_y != '0) ? alu_x % alu_y : '0;
      3'b101:  alu_result = DW'(alu_x > alu_y);
      3'b110:  alu_result = alu_x >> 1;
      default: alu_result = alu_x << 1;
    endcase
    alu_status = (alu_result == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake is checked against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      #1;
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got tag %0d result %0d, required no response", rsp_tag, rsp_result);
        end else begin
          e = sb.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_zero",   32'(rsp_zero),   32'(e.zero));
          check("rsp_err",    32'(rsp_err),    32'(e.err));
          check("rsp_tag",    32'(rsp_tag),    32'(e.tag));
        end
      end
    end
  end

  // Offer one command (called at a negedge); expectation queued on acceptance
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [DW-1:0] eres, input logic ez, input logic ee);
    int   n;
    exp_t e;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_x      = x;
    cmd_y      = y;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge aclk);
    e.res  = eres;
    e.zero = ez;
    e.err  = ee;
    e.tag  = exp_tag;
    sb.push_back(e);
    exp_tag = exp_tag + 3'd1;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < LIMIT) begin
      @(negedge aclk);
      n++;
    end
    check("drain_done", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic check_reset_outs();
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_zero",   32'(rsp_zero),   32'd0);
    check("rst_rsp_err",    32'(rsp_err),    32'd0);
    check("rst_rsp_tag",    32'(rsp_tag),    32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_x",      32'(alu_x),      32'd0);
    check("rst_alu_y",      32'(alu_y),      32'd0);
  endtask

  // Assert reset immediately (called at a negedge) across two rising edges
  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    sb.delete();
    exp_tag   = '0;
    repeat (2) @(negedge aclk);
    reset = 1'b0;
    check_reset_outs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_v, cnt_r;
    @(negedge aclk);
    do_reset();

    // Single add with latency check: valid exactly three edges after acceptance
    rsp_ready = 1'b1;
    issue(3'b001, 13'd5, 13'd7, 13'd12, 1'b0, 1'b0);
    check("lat_edge0", 32'(rsp_valid), 32'd0);
    @(negedge aclk); check("lat_edge1", 32'(rsp_valid), 32'd0);
    @(negedge aclk); check("lat_edge2", 32'(rsp_valid), 32'd0);
    @(negedge aclk); check("lat_edge3", 32'(rsp_valid), 32'd1);
    drain();

    // Divide by zero: error response and ALU drive left at the add
    issue(3'b011, 13'd9, 13'd0, 13'd0, 1'b1, 1'b1);
    drain();
    check("div0_alu_opcode", 32'(alu_opcode), 32'd1);
    check("div0_alu_x",      32'(alu_x),      32'd5);
    check("div0_alu_y",      32'(alu_y),      32'd7);

    // Zero flag from subtraction
    issue(3'b010, 13'd4, 13'd4, 13'd0, 1'b1, 1'b0);
    drain();

    // Remaining opcodes and wrap boundaries, under toggling response backpressure
    fork
      begin
        issue(3'b000, 13'd100,  13'd0, 13'd100,  1'b0, 1'b0);
        issue(3'b011, 13'd100,  13'd7, 13'd14,   1'b0, 1'b0);
        issue(3'b100, 13'd100,  13'd7, 13'd2,    1'b0, 1'b0);
        issue(3'b101, 13'd9,    13'd3, 13'd1,    1'b0, 1'b0);
        issue(3'b101, 13'd3,    13'd9, 13'd0,    1'b1, 1'b0);
        issue(3'b110, 13'd1,    13'd0, 13'd0,    1'b1, 1'b0);
        issue(3'b111, 13'd4096, 13'd0, 13'd0,    1'b1, 1'b0);
        issue(3'b111, 13'd5,    13'd0, 13'd10,   1'b0, 1'b0);
        issue(3'b010, 13'd3,    13'd5, 13'd8190, 1'b0, 1'b0);
        issue(3'b001, 13'd8191, 13'd1, 13'd0,    1'b1, 1'b0);
        issue(3'b100, 13'd5,    13'd0, 13'd0,    1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge aclk);
          rsp_ready = (i % 3 != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    drain();

    // Full FIFO: four queued plus one held in RESP blocks the sixth command
    @(negedge aclk);
    do_reset();
    rsp_ready = 1'b0;
    issue(3'b001, 13'd10,   13'd20, 13'd30,   1'b0, 1'b0);
    issue(3'b010, 13'd50,   13'd8,  13'd42,   1'b0, 1'b0);
    issue(3'b111, 13'd3,    13'd0,  13'd6,    1'b0, 1'b0);
    issue(3'b110, 13'd9,    13'd0,  13'd4,    1'b0, 1'b0);
    issue(3'b101, 13'd7,    13'd2,  13'd1,    1'b0, 1'b0);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge aclk);
    check("full_cmd_ready_held", 32'(cmd_ready), 32'd0);
    check("full_rsp_valid",      32'(rsp_valid), 32'd1);
    check("full_rsp_tag",        32'(rsp_tag),   32'd0);
    fork
      issue(3'b000, 13'd8191, 13'd0, 13'd8191, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge aclk);
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset while the first of three commands waits on the ALU
    issue(3'b001, 13'd1, 13'd1, 13'd2, 1'b0, 1'b0);
    issue(3'b001, 13'd2, 13'd2, 13'd4, 1'b0, 1'b0);
    issue(3'b001, 13'd3, 13'd3, 13'd6, 1'b0, 1'b0);
    check("midrst_alu_x", 32'(alu_x), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_reset();
    cnt_v = 0;
    cnt_r = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (rsp_valid)  cnt_v++;
      if (!cmd_ready) cnt_r++;
    end
    check("postrst_rsp_valid_cycles", 32'(cnt_v), 32'd0);
    check("postrst_cmd_ready_low",    32'(cnt_r), 32'd0);

    // Nine commands from reset: tags 0..7 then wrap to 0
    for (int i = 0; i < 9; i++) begin
      issue(3'b001, DW'(i), 13'd1, DW'(i + 1), 1'b0, 1'b0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
